// File: rtl/silencer_settings_loader_pkg.sv
// Shared types and constants for the silencer settings path: the committed
// settings bundle, register word offsets, reset defaults and the loader FSM states.
package silencer_settings_loader_pkg;

   typedef struct packed {
      logic        update;
      logic        mode;
      logic [15:0] update_rate_intensity;
      logic [15:0] update_rate_phase;
      logic [15:0] completion_steps_intensity;
      logic [15:0] completion_steps_phase;
   } silencer_settings_t;

   localparam int SILENCER_OFS_FLAG        = 0;
   localparam int SILENCER_OFS_RATE_INT    = 1;
   localparam int SILENCER_OFS_RATE_PHASE  = 2;
   localparam int SILENCER_OFS_STEPS_INT   = 3;
   localparam int SILENCER_OFS_STEPS_PHASE = 4;
   localparam int SILENCER_NUM_WORDS       = 5;

   localparam logic        SILENCER_DEFAULT_MODE        = 1'b1;
   localparam logic [15:0] SILENCER_DEFAULT_RATE_INT    = 16'd256;
   localparam logic [15:0] SILENCER_DEFAULT_RATE_PHASE  = 16'd256;
   localparam logic [15:0] SILENCER_DEFAULT_STEPS_INT   = 16'd10;
   localparam logic [15:0] SILENCER_DEFAULT_STEPS_PHASE = 16'd40;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_ISSUE,
      LD_DRAIN,
      LD_COMMIT
   } loader_state_t;

   // A rate or step count of zero would stall the silencer, so it is forced to 1.
   function automatic logic [15:0] nonzero(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

   function automatic silencer_settings_t silencer_settings_default();
      silencer_settings_t s;
      s.update                     = 1'b0;
      s.mode                       = SILENCER_DEFAULT_MODE;
      s.update_rate_intensity      = SILENCER_DEFAULT_RATE_INT;
      s.update_rate_phase          = SILENCER_DEFAULT_RATE_PHASE;
      s.completion_steps_intensity = SILENCER_DEFAULT_STEPS_INT;
      s.completion_steps_phase     = SILENCER_DEFAULT_STEPS_PHASE;
      return s;
   endfunction

endpackage

// File: rtl/silencer_settings_loader_tracker.sv
// Enable/index delay line matching a pipelined BRAM read port; emits the index
// of each returning word together with a valid flag, DEPTH cycles after issue.
module bram_read_tracker #(
   parameter int DEPTH = 2,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic             valid,
   output logic [IDX_W-1:0] valid_idx
);

   logic [DEPTH-1:0] v_pipe;
   logic [IDX_W-1:0] idx_pipe [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_pipe <= '0;
         for (int i = 0; i < DEPTH; i++) idx_pipe[i] <= '0;
      end else begin
         v_pipe[0]   <= en;
         idx_pipe[0] <= idx;
         for (int i = 1; i < DEPTH; i++) begin
            v_pipe[i]   <= v_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
      end
   end

   assign valid     = v_pipe[DEPTH-1];
   assign valid_idx = idx_pipe[DEPTH-1];

endmodule

// File: rtl/silencer_settings_loader.sv
// Fetches the five silencer register words from controller BRAM on request,
// sanitises them and commits them to the silencer as one atomic update.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LD_IDLE   | waiting for req
// LD_ISSUE  | five read enables, addresses BASE_ADDR+0..4
// LD_DRAIN  | waiting for the last word to return from BRAM
// LD_COMMIT | outputs hold the new set, update strobe high for one cycle
module silencer_settings_loader
   import silencer_settings_loader_pkg::*;
#(
   parameter int                ADDR_W     = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(8'h40),
   parameter int                RD_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   output logic               busy,
   output logic               bram_en,
   output logic [ADDR_W-1:0]  bram_addr,
   input  logic [15:0]        bram_dout,
   output silencer_settings_t silencer_settings
);

   localparam logic [2:0] LAST_IDX = 3'(SILENCER_NUM_WORDS - 1);

   loader_state_t      state_q, state_d;
   logic [2:0]         issue_q, issue_d;
   logic               pending_q, pending_d;
   logic               commit_load;
   logic               trk_valid;
   logic [2:0]         trk_idx;
   logic               last_capture;
   logic [15:0]        shadow_q    [SILENCER_NUM_WORDS];
   logic [15:0]        shadow_next [SILENCER_NUM_WORDS];
   silencer_settings_t committed_q;

   bram_read_tracker #(
      .DEPTH (RD_LATENCY),
      .IDX_W (3)
   ) u_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (bram_en),
      .idx       (issue_q),
      .valid     (trk_valid),
      .valid_idx (trk_idx)
   );

   always_comb begin
      for (int i = 0; i < SILENCER_NUM_WORDS; i++) shadow_next[i] = shadow_q[i];
      if (trk_valid) shadow_next[trk_idx] = bram_dout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SILENCER_NUM_WORDS; i++) shadow_q[i] <= '0;
      end else begin
         for (int i = 0; i < SILENCER_NUM_WORDS; i++) shadow_q[i] <= shadow_next[i];
      end
   end

   assign last_capture = trk_valid && (trk_idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LD_IDLE;
         issue_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      issue_d     = issue_q;
      pending_d   = pending_q;
      commit_load = 1'b0;
      case (state_q)
         LD_IDLE: begin
            if (req) begin
               state_d = LD_ISSUE;
               issue_d = '0;
            end
         end
         LD_ISSUE: begin
            if (issue_q == LAST_IDX) state_d = LD_DRAIN;
            else                     issue_d = issue_q + 3'd1;
         end
         LD_DRAIN: begin
            if (last_capture) begin
               state_d     = LD_COMMIT;
               commit_load = 1'b1;
            end
         end
         LD_COMMIT: begin
            pending_d = 1'b0;
            if (pending_q || req) begin
               state_d = LD_ISSUE;
               issue_d = '0;
            end else begin
               state_d = LD_IDLE;
            end
         end
         default: state_d = LD_IDLE;
      endcase
      if (req && (state_q == LD_ISSUE || state_q == LD_DRAIN)) pending_d = 1'b1;
   end

   // Loaded on the edge into LD_COMMIT so the new set is visible exactly
   // while the update strobe is high, including the word arriving that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         committed_q <= silencer_settings_default();
      end else if (commit_load) begin
         committed_q.update                     <= 1'b0;
         committed_q.mode                       <= shadow_next[SILENCER_OFS_FLAG][0];
         committed_q.update_rate_intensity      <= nonzero(shadow_next[SILENCER_OFS_RATE_INT]);
         committed_q.update_rate_phase          <= nonzero(shadow_next[SILENCER_OFS_RATE_PHASE]);
         committed_q.completion_steps_intensity <= nonzero(shadow_next[SILENCER_OFS_STEPS_INT]);
         committed_q.completion_steps_phase     <= nonzero(shadow_next[SILENCER_OFS_STEPS_PHASE]);
      end
   end

   always_comb begin
      silencer_settings        = committed_q;
      silencer_settings.update = (state_q == LD_COMMIT);
   end

   assign busy      = (state_q != LD_IDLE);
   assign bram_en   = (state_q == LD_ISSUE);
   assign bram_addr = bram_en ? (BASE_ADDR + ADDR_W'(issue_q)) : '0;

endmodule
